// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing and receiver states.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int CLOCKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset value selectable.
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling, valid/ready holding register,
// framing-error and overrun pulses.
//
// state    | meaning
// ---------+---------------------------------------------------------
// RX_IDLE  | line idle, waiting for a falling edge on rx_s
// RX_START | counting to mid-start-bit, rejects short low glitches
// RX_DATA  | sampling 8 data bits LSB first at mid-bit
// RX_STOP  | sampling the stop bit at mid-bit
// RX_BREAK | stop bit was low; wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = CLOCKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_rx,
  input  logic                      in_ready,
  output logic [UART_DATA_BITS-1:0] out_data,
  output logic                      out_valid,
  output logic                      out_frame_err,
  output logic                      out_overrun,
  output logic                      out_busy
);

  localparam int half_bit = clocks_per_bit / 2;
  localparam int CW       = $clog2(clocks_per_bit);

  localparam logic [CW-1:0] HALF_LAST = CW'(half_bit - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(clocks_per_bit - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_e                 state_q;
  logic [CW-1:0]             cycle_count_q;
  logic [3:0]                bit_count_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      deliver_q;
  logic                      frame_err_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      overrun_q;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (in_rx),
    .q_o   (rx_s)
  );

  // Frame decoder: start detect, mid-bit sampling, stop check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RX_IDLE;
      cycle_count_q <= '0;
      bit_count_q   <= '0;
      shift_q       <= '0;
      deliver_q     <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_q       <= RX_START;
            cycle_count_q <= '0;
          end
        end
        RX_START: begin
          if (cycle_count_q == HALF_LAST) begin
            cycle_count_q <= '0;
            if (!rx_s) begin
              state_q     <= RX_DATA;
              bit_count_q <= '0;
            end else begin
              state_q <= RX_IDLE;
            end
          end else begin
            cycle_count_q <= cycle_count_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cycle_count_q == BIT_LAST) begin
            shift_q       <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
            cycle_count_q <= '0;
            bit_count_q   <= bit_count_q + 4'd1;
            if (bit_count_q == LAST_BIT) begin
              state_q <= RX_STOP;
            end
          end else begin
            cycle_count_q <= cycle_count_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cycle_count_q == BIT_LAST) begin
            cycle_count_q <= '0;
            if (rx_s) begin
              deliver_q <= 1'b1;
              state_q   <= RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RX_BREAK;
            end
          end else begin
            cycle_count_q <= cycle_count_q + CW'(1);
          end
        end
        RX_BREAK: begin
          if (rx_s) begin
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  // Holding register: load on delivery, clear on transfer, drop when full.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (deliver_q) begin
        if (!valid_q || in_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && in_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign out_frame_err = frame_err_q;
  assign out_overrun   = overrun_q;
  assign out_busy      = (state_q != RX_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the 8N1 line produced by the team's buffered UART transmitter. Used for loopback and for host-to-FPGA traffic.
- Synchronizes the asynchronous line, detects the start bit and samples each bit at mid-bit. Delivers one byte at a time through a valid/ready holding register and flags framing errors and overruns.
- Bit timing matches the transmitter: clocks_per_bit clk cycles per bit, no oversampling clock.

Parameters:
- clocks_per_bit, 4, clk cycles per serial bit. Must be >= 4. Must equal the transmitter's setting.
- half_bit, clocks_per_bit/2 (integer division, derived, not overridable), cycles from start-edge detection to mid-start-bit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_rx  in  1  asynchronous serial line, idle high
- in_ready  in  1  consumer accepts out_data this cycle
- out_data  out  8  received byte, held stable while out_valid=1
- out_valid  out  1  byte available
- out_frame_err  out  1  one-cycle pulse: stop bit sampled 0
- out_overrun  out  1  one-cycle pulse: byte dropped because holding register full
- out_busy  out  1  receiver is in any state other than IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset; all state updates on posedge clk.
- Reset values:
  - sync flops = 1, state = IDLE, cycle_count = 0, bit_count = 0, shift = 0.
  - out_data = 0, out_valid = 0, out_frame_err = 0, out_overrun = 0, out_busy = 0.
  - Reset mid-frame abandons the frame silently: no error pulse, and any held byte is cleared.
- Synchronizer: two flops on in_rx. The FSM sees only the second flop, rx_s.
- States:
  - IDLE: rx_s=0 -> START, cycle_count=0.
  - START: counts to half_bit-1.
    - rx_s=0 at that point -> DATA, cycle_count=0, bit_count=0.
    - rx_s=1 at that point -> IDLE. This is a glitch reject; no pulse.
  - DATA:
    - At cycle_count=clocks_per_bit-1: shift = {rx_s, shift[7:1]} (LSB first), cycle_count=0, bit_count++.
    - After the 8th sample -> STOP.
  - STOP:
    - At cycle_count=clocks_per_bit-1, sample rx_s.
    - rx_s=1 -> deliver byte, go to IDLE.
    - rx_s=0 -> pulse out_frame_err, discard byte, go to BREAK.
  - BREAK: wait for rx_s=1 -> IDLE. This prevents a held-low line from being decoded as 0x00 streams.
- Sampling and counters:
  - Every bit after the start bit is sampled at its middle.
  - Returning to IDLE at mid-stop-bit lets back-to-back frames resynchronize on the next falling edge.
  - cycle_count width is $clog2(clocks_per_bit). bit_count is 4 bits.
  - Counters never wrap in normal operation; every terminal value is compared explicitly.
- Latency: if in_rx is first sampled low at edge t0, out_valid=1 after edge t0 + 3 + half_bit + 9*clocks_per_bit. That is edge t0+41 for clocks_per_bit=4.
- Handshake:
  - A transfer occurs on any cycle with out_valid && in_ready.
  - out_valid falls the edge after the transfer unless a new byte is delivered in the same cycle.
- Delivery while the holding register is occupied:
  - out_valid=0: load out_data and set out_valid.
  - out_valid=1 and in_ready=1 in the same cycle: load the new byte; out_valid stays 1; no overrun.
  - out_valid=1 and in_ready=0: keep the old byte, drop the new one, pulse out_overrun.
- Frame error and overrun are independent. A framing-error frame never causes an overrun.

Decomposition:
- Package uart_pkg holds:
  - rx state enum: IDLE, START, DATA, STOP, BREAK;
  - UART_DATA_BITS = 8;
  - default CLOCKS_PER_BIT = 4 (shared with the transmitter).
- Sub-module uart_sync2: two-flop synchronizer, reset value parameterised (1 here). It is reused for other async inputs.
- FSM and holding register stay in uart_rx.

Test Plan:
- Byte 0x55, clocks_per_bit=4, in_ready=1 -> out_valid pulses one cycle at t0+41 with out_data=0x55; no error pulses.
- Back-to-back frames 0xA5 then 0x3C with no idle gap, in_ready=1 -> two deliveries exactly 40 cycles apart, data 0xA5, 0x3C.
- Low glitch of 1 cycle on idle line -> state returns to IDLE; out_busy high for at most half_bit+1 cycles; no out_valid and no error.
- Frame 0x81 with stop bit forced 0, then line held low 100 cycles, then high, then valid frame 0x42 -> out_frame_err one pulse only; no 0x00 bytes; then 0x42 delivered.
- Overrun and same-cycle accept:
  - in_ready=0, send 0x11 then 0x22 -> out_data stays 0x11, out_overrun pulses once at the second delivery.
  - Repeat with in_ready=1 raised exactly on the second delivery cycle -> out_data=0x22, out_valid stays 1, no overrun.
- Reset asserted mid-DATA of frame 0xFF for 1 cycle, then valid frame 0x5A -> no output from the aborted frame; 0x5A delivered correctly; all outputs 0 the cycle after reset.
